// File: rtl/prog_clock_divider.sv
// rtl/prog_clock_divider.sv - multi-channel programmable 50% clock divider and tick generator
module prog_clock_divider #(
    parameter int NUM_CH       = 4,
    parameter int DIV_W        = 20,
    parameter int DEFAULT_HALF = 50000,
    parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_half,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    // Per-channel state. cnt runs 1..h_act within each half-period.
    logic [DIV_W-1:0]  cnt_q    [NUM_CH];
    logic [DIV_W-1:0]  cnt_d    [NUM_CH];
    logic [DIV_W-1:0]  h_act_q  [NUM_CH];
    logic [DIV_W-1:0]  h_act_d  [NUM_CH];
    logic [DIV_W-1:0]  h_pend_q [NUM_CH];
    logic [DIV_W-1:0]  h_pend_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_d;
    logic [NUM_CH-1:0] clk_q;
    logic [NUM_CH-1:0] clk_d;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;

    logic [NUM_CH-1:0] wr_hit;
    logic [DIV_W-1:0]  wr_val;
    logic [NUM_CH-1:0] boundary;

    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0] DEF_HALF = DIV_W'(DEFAULT_HALF);

    // Decode the write port: one-hot channel hit, out-of-range selects dropped,
    // and a zero half-period clamped to one (fastest legal output, f_clk/2).
    always_comb begin
        wr_hit = '0;
        if (wr_en && (32'(wr_ch) < NUM_CH)) begin
            wr_hit = NUM_CH'(1) << wr_ch;
        end
        wr_val = (wr_half == '0) ? ONE : wr_half;
    end

    // Boundary = last cycle of the current half-period. The >= keeps a channel
    // from ever running past its half-period even if state were disturbed.
    always_comb begin
        boundary = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            boundary[i] = (cnt_q[i] >= h_act_q[i]);
        end
    end

    // Next-state: sync beats run/hold; a pending value is only promoted at a
    // toggle boundary or on sync, so the active half-period never changes mid-half.
    // A write is captured after promotion, so a write landing in a boundary cycle
    // waits for the following boundary.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]    = cnt_q[i];
            h_act_d[i]  = h_act_q[i];
            h_pend_d[i] = h_pend_q[i];
            pend_d[i]   = pend_q[i];
            clk_d[i]    = clk_q[i];
            tick_d[i]   = 1'b0;

            if (sync) begin
                cnt_d[i] = ONE;
                clk_d[i] = 1'b0;
                if (pend_q[i]) begin
                    h_act_d[i] = h_pend_q[i];
                    pend_d[i]  = 1'b0;
                end
            end else if (en[i]) begin
                if (boundary[i]) begin
                    cnt_d[i]  = ONE;
                    clk_d[i]  = ~clk_q[i];
                    tick_d[i] = ~clk_q[i];
                    if (pend_q[i]) begin
                        h_act_d[i] = h_pend_q[i];
                        pend_d[i]  = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + ONE;
                end
            end

            if (wr_hit[i]) begin
                h_pend_d[i] = wr_val;
                pend_d[i]   = 1'b1;
            end
        end
    end

    // State registers; reset drops all pending writes and restores the default rate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= ONE;
                h_act_q[i]  <= DEF_HALF;
                h_pend_q[i] <= '0;
            end
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                h_act_q[i]  <= h_act_d[i];
                h_pend_q[i] <= h_pend_d[i];
            end
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// tb/tb_prog_clock_divider.sv - self-checking bench for prog_clock_divider
module tb_prog_clock_divider;

    localparam int NCH    = 4;
    localparam int DW     = 20;
    localparam int TB_DEF = 200;
    localparam int CW     = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NCH-1:0] en = '0;
    logic           sync = 1'b0;
    logic           wr_en = 1'b0;
    logic [CW-1:0]  wr_ch = '0;
    logic [DW-1:0]  wr_half = '0;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pending;

    prog_clock_divider #(
        .NUM_CH(NCH),
        .DIV_W(DW),
        .DEFAULT_HALF(TB_DEF),
        .CH_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sync(sync),
        .wr_en(wr_en),
        .wr_ch(wr_ch),
        .wr_half(wr_half),
        .clk_out(clk_out),
        .tick(tick),
        .pending(pending)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Reference model: per channel, level of the divided clock, number of enabled
    // cycles already spent in the current half, active and queued half-periods.
    int m_h    [NCH];
    int m_hp   [NCH];
    int m_el   [NCH];
    bit m_pend [NCH];
    bit m_lvl  [NCH];
    bit m_tick [NCH];

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < NCH; i++) begin
            if (!rst) begin
                m_h[i] = TB_DEF; m_hp[i] = 0; m_el[i] = 0;
                m_pend[i] = 0; m_lvl[i] = 0; m_tick[i] = 0;
            end else begin
                m_tick[i] = 0;
                if (sync) begin
                    if (m_pend[i]) begin m_h[i] = m_hp[i]; m_pend[i] = 0; end
                    m_el[i] = 0;
                    m_lvl[i] = 0;
                end else if (en[i]) begin
                    m_el[i] = m_el[i] + 1;
                    if (m_el[i] == m_h[i]) begin
                        m_lvl[i] = !m_lvl[i];
                        m_tick[i] = m_lvl[i];
                        m_el[i] = 0;
                        if (m_pend[i]) begin m_h[i] = m_hp[i]; m_pend[i] = 0; end
                    end
                end
                if (wr_en && int'(wr_ch) < NCH && int'(wr_ch) == i) begin
                    m_hp[i] = (wr_half == 0) ? 1 : int'(wr_half);
                    m_pend[i] = 1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [NCH-1:0] ec, et, ep;
        if (chk_on) begin
            for (int i = 0; i < NCH; i++) begin
                ec[i] = m_lvl[i]; et[i] = m_tick[i]; ep[i] = m_pend[i];
            end
            n_tests++;
            if (clk_out !== ec || tick !== et || pending !== ep) begin
                n_fail++;
                $display("FAIL model t=%0t: clk_out=%b want %b tick=%b want %b pending=%b want %b",
                         $time, clk_out, ec, tick, et, pending, ep);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic write(input int ch, input int h);
        wr_en = 1'b1; wr_ch = CW'(ch); wr_half = DW'(h);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_clear(input int ch, input int limit);
        int t = 0;
        while (pending[ch] && t < limit) begin @(negedge clk); t++; end
        check($sformatf("pending clear ch%0d", ch), int'(pending[ch]), 0);
    endtask

    // Period (rise to rise), high length and tick count over one full period.
    task automatic measure(input int ch, input int limit,
                           output int period, output int high_len, output int nticks);
        int t = 0, first = -1, second = -1;
        bit prev = clk_out[ch];
        high_len = 0; nticks = 0;
        while (t < limit) begin
            @(negedge clk); t++;
            if (clk_out[ch] && !prev) begin
                if (first < 0) first = t;
                else begin second = t; break; end
            end
            if (first >= 0) begin
                if (clk_out[ch]) high_len++;
                if (tick[ch]) nticks++;
            end
            prev = clk_out[ch];
        end
        period = (second >= 0) ? second - first : -1;
    endtask

    initial begin
        int p, h, nt, hi, lo, bad, cnt;
        int first [NCH];
        bit prev, found;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset clk_out", int'(clk_out), 0);
        check("reset tick", int'(tick), 0);
        check("reset pending", int'(pending), 0);
        rst = 1'b1; en = '1; chk_on = 1'b1;

        // Default rate
        measure(0, 1500, p, h, nt);
        check("default period", p, 2 * TB_DEF);
        check("default high", h, TB_DEF);
        check("default ticks", nt, 1);
        check("default pending", int'(pending), 0);

        // ch1 = 3
        write(1, 3);
        check("ch1 pending after write", int'(pending[1]), 1);
        wait_clear(1, 600);
        measure(1, 100, p, h, nt);
        check("ch1 period", p, 6);
        check("ch1 high", h, 3);
        check("ch1 ticks", nt, 1);
        measure(0, 1500, p, h, nt);
        check("ch0 untouched period", p, 2 * TB_DEF);

        // ch2 = 0 clamps to 1
        write(2, 0);
        wait_clear(2, 600);
        measure(2, 20, p, h, nt);
        check("ch2 period", p, 2);
        check("ch2 high", h, 1);
        cnt = 0;
        repeat (10) begin @(negedge clk); cnt += int'(tick[2]); end
        check("ch2 ticks in 10", cnt, 5);

        // Last write wins
        write(0, 5);
        write(0, 2);
        check("ch0 pending", int'(pending[0]), 1);
        wait_clear(0, 600);
        measure(0, 50, p, h, nt);
        check("ch0 last-wins period", p, 4);

        // Write exactly in a boundary cycle (aligned with sync; ch0 H=2)
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        write(0, 4);
        write(0, 7);
        check("bnd clk_out high", int'(clk_out[0]), 1);
        check("bnd pending 7", int'(pending[0]), 1);
        hi = 0;
        while (clk_out[0] && hi < 50) begin hi++; @(negedge clk); end
        check("bnd high len", hi, 4);
        check("bnd pending cleared", int'(pending[0]), 0);
        lo = 0;
        while (!clk_out[0] && lo < 50) begin lo++; @(negedge clk); end
        check("bnd low len", lo, 7);

        // Hold ch3 with H=10
        write(3, 10);
        wait_clear(3, 600);
        found = 0; prev = clk_out[3];
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (clk_out[3] && !prev) begin found = 1; break; end
            prev = clk_out[3];
        end
        check("hold rise found", int'(found), 1);
        hi = 1;
        repeat (4) begin @(negedge clk); hi += int'(clk_out[3]); end
        en[3] = 1'b0;
        bad = 0;
        repeat (37) begin
            @(negedge clk);
            hi += int'(clk_out[3]);
            if (!clk_out[3] || tick[3]) bad++;
        end
        en[3] = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (!clk_out[3]) break;
            hi++;
        end
        check("hold frozen", bad, 0);
        check("hold high samples", hi, 47);

        // Sync with H = 3,5,7,9
        write(0, 3); write(1, 5); write(2, 7); write(3, 9);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        check("sync clk_out", int'(clk_out), 0);
        check("sync pending", int'(pending), 0);
        for (int i = 0; i < NCH; i++) first[i] = -1;
        for (int k = 1; k <= 12; k++) begin
            for (int i = 0; i < NCH; i++) if (tick[i] && first[i] < 0) first[i] = k;
            @(negedge clk);
        end
        check("sync tick ch0", first[0], 4);
        check("sync tick ch1", first[1], 6);
        check("sync tick ch2", first[2], 8);
        check("sync tick ch3", first[3], 10);

        // Out-of-range write
        write(4, 1);
        check("oor pending", int'(pending), 0);
        measure(0, 50, p, h, nt);
        check("oor ch0 period", p, 6);

        // Asynchronous reset mid-operation
        write(1, 20);
        check("pre-reset pending", int'(pending[1]), 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async clk_out", int'(clk_out), 0);
        check("async tick", int'(tick), 0);
        check("async pending", int'(pending), 0);
        @(negedge clk);
        rst = 1'b1;
        measure(0, 1500, p, h, nt);
        check("post-reset period", p, 2 * TB_DEF);

        // Randomized traffic against the model
        repeat (3000) begin
            en   = NCH'($urandom) | NCH'($urandom);
            sync = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) begin
                wr_en = 1'b1;
                wr_ch = CW'($urandom_range(0, 7));
                wr_half = DW'($urandom_range(0, 12));
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
        wr_en = 1'b0; sync = 1'b0; en = '1;
        repeat (5) @(negedge clk);
        chk_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
- Multi-channel, run-time programmable clock divider and tick generator. It replaces fixed-ratio dividers in the display and sensor timing paths.
- Each channel produces a 50%-duty divided clock and a one-cycle tick strobe, both derived from the 100 MHz system clock.
- Half-period values are written through a simple register-write port. Each new value takes effect glitch-free at the channel's next toggle boundary.
- A global sync input restarts all channels phase-aligned.

Parameters:
- NUM_CH, 4: number of independent divider channels (1..16).
- DIV_W, 20: width of the half-period counter and divisor registers.
- DEFAULT_HALF, 50000: half-period loaded into every channel at reset. This gives 1 kHz from 100 MHz.
- CH_W, $clog2(NUM_CH) (minimum 1): width of the channel select.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset. rst=0 resets the block immediately; release is synchronous to clk.
- en  in  NUM_CH  per-channel run enable.
- sync  in  1  one-cycle pulse that restarts all channels phase-aligned.
- wr_en  in  1  half-period write strobe.
- wr_ch  in  CH_W  target channel for the write.
- wr_half  in  DIV_W  new half-period, in clk cycles.
- clk_out  out  NUM_CH  divided clocks, registered.
- tick  out  NUM_CH  one-cycle strobe on each clk_out rising edge, registered.
- pending  out  NUM_CH  a written value is waiting for that channel's next toggle boundary.

Behaviour:
- Per-channel state:
  - cnt: DIV_W bits, counts 1..H.
  - H_act: active half-period.
  - H_pend and pending flag.
  - clk_out and tick registers.
- Reset (rst=0, asynchronous), for every channel:
  - cnt=1, H_act=DEFAULT_HALF, H_pend=0, pending=0, clk_out=0, tick=0.
- Run (en[i]=1, sync=0):
  - If cnt<H_act: cnt increments each cycle.
  - If cnt==H_act (boundary): clk_out toggles, cnt<=1.
  - At a boundary with pending=1: H_act<=H_pend and pending clears.
  - Resulting period is 2*H_act clk cycles. Output frequency is f_clk/(2*H_act). Duty is exactly 50%.
- tick[i]:
  - High for exactly one cycle: the first cycle in which clk_out[i] is 1 after a 0->1 toggle.
  - Low at all other times.
- Hold (en[i]=0):
  - cnt and clk_out hold their values. tick is 0.
  - A pending value stays pending.
  - When en returns to 1, counting resumes from the held cnt. No glitch occurs.
- Write (wr_en=1):
  - If wr_ch<NUM_CH: H_pend[wr_ch]<=wr_half and pending<=1.
  - If wr_ch>=NUM_CH: the write is ignored.
  - wr_half=0 is clamped to 1, giving f_clk/2.
  - A later write before the boundary overwrites H_pend. Last write wins.
- Write in a boundary cycle of the same channel:
  - Any previously pending value is applied at this boundary.
  - The new value is captured into H_pend with pending=1, and applies at the following boundary.
- Write while a channel is disabled: takes effect at the first boundary after re-enable.
- sync=1 (takes priority over run and hold), for all channels:
  - cnt<=1, clk_out<=0, tick<=0.
  - If pending: H_act<=H_pend and pending clears.
  - A write in the same cycle as sync is captured as pending and applies at the next boundary.
- Counter arithmetic: unsigned. cnt never exceeds H_act, so there is no wrap-around at 2^DIV_W-1.
- Latency:
  - A write is visible on pending the next cycle.
  - clk_out and tick change on the clk edge that ends a boundary cycle.
- Reset mid-operation: all outputs return to their reset values immediately, and pending writes are lost.

Test Plan:
- Reset, en=4'hF, no writes, run 200000 cycles -> every clk_out has period 100000 cycles with high=low=50000; one tick per period; pending=0.
- Write ch1 wr_half=3, wait for the boundary -> pending[1]=1 until the boundary, then clk_out[1] has period 6 (3 high/3 low); other channels unaffected.
- Write ch2 wr_half=0 -> after the boundary, clk_out[2] toggles every cycle (period 2); tick[2] is high every other cycle.
- Write ch0=5, then ch0=2 before the boundary; in a separate run, write ch0=7 exactly in a boundary cycle -> first case: only 2 is applied; second case: the old pending value is applied now and 7 at the next boundary.
- en[3] low for 37 cycles mid-period with H=10 -> clk_out[3] and cnt frozen and tick[3]=0 while low; after re-enable the remaining half-period completes with no short pulse.
- Channels set to H=3, 5, 7, 9 then sync pulse; also wr_ch=NUM_CH write and rst=0 mid-period -> after sync all clk_out=0 and first ticks occur at cycles 4, 6, 8, 10 after sync; out-of-range write changes nothing; rst=0 forces all outputs to 0 asynchronously and restores H=DEFAULT_HALF.
